pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and stall controller for a five-stage pipeline. It decides each
// cycle which pipeline latches advance, which latches get a bubble, and
// whether the PC advances. It also tracks a sticky halt condition and counts
// stall cycles.
//
// Ports
//   CLK          in   clock, all state updates on the rising edge
//   nRST         in   asynchronous active-low reset
//   ihit         in   instruction fetch completed this cycle
//   dhit         in   data access completed this cycle
//   memDRE       in   MEM-stage instruction reads data memory
//   memDWE       in   MEM-stage instruction writes data memory
//   memHALT      in   halt instruction present in MEM stage
//   loaduse      in   ID-stage instruction depends on the EX-stage load
//   branchTaken  in   EX stage resolved a taken branch/jump
//   ifidW..memwbW out latch advance enables
//   ifidRST..exmemRST out latch flush (bubble) requests
//   pcEN         out  PC update enable
//   halt         out  registered processor-halted flag
//   stallCount   out  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        memDRE,
    input  logic        memDWE,
    input  logic        memHALT,
    input  logic        loaduse,
    input  logic        branchTaken,
    output logic        ifidW,
    output logic        idexW,
    output logic        exmemW,
    output logic        memwbW,
    output logic        ifidRST,
    output logic        idexRST,
    output logic        exmemRST,
    output logic        pcEN,
    output logic        halt,
    output logic [15:0] stallCount
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Control bundle order:
    // {ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, pcEN}
    localparam logic [7:0] CTL_NONE   = 8'b0000_000_0;
    localparam logic [7:0] CTL_NORMAL = 8'b1111_000_1;
    localparam logic [7:0] CTL_BRANCH = 8'b0011_110_1;
    localparam logic [7:0] CTL_LDUSE  = 8'b0011_010_0;
    localparam logic [7:0] CTL_IMISS  = 8'b0111_100_0;

    state_t     state;
    state_t     nextState;
    state_t     runNext;
    logic [7:0] runCtl;
    logic [7:0] ctl;
    logic       dataWait;

    assign dataWait = (memDRE | memDWE) & ~dhit;

    // Priority decode of the RUN-state conditions. DWAIT reuses this once
    // the data access completes, at which point dataWait is already false.
    always_comb begin
        runCtl  = CTL_NORMAL;
        runNext = RUN;
        if (memHALT) begin
            runCtl  = CTL_NONE;
            runNext = HALTED;
        end else if (dataWait) begin
            runCtl  = CTL_NONE;
            runNext = DWAIT;
        end else if (branchTaken) begin
            runCtl = CTL_BRANCH;
        end else if (loaduse) begin
            runCtl = CTL_LDUSE;
        end else if (!ihit) begin
            runCtl = CTL_IMISS;
        end
    end

    // State-dependent selection of the control bundle and next state.
    always_comb begin
        ctl       = CTL_NONE;
        nextState = state;
        case (state)
            RUN: begin
                ctl       = runCtl;
                nextState = runNext;
            end
            DWAIT: begin
                if (dhit) begin
                    ctl       = runCtl;
                    nextState = runNext;
                end
            end
            HALTED: begin
                ctl       = CTL_NONE;
                nextState = HALTED;
            end
            default: begin
                ctl       = CTL_NONE;
                nextState = RUN;
            end
        endcase
    end

    // Reset forces every enable and flush low without waiting for a clock.
    assign {ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, pcEN} =
        nRST ? ctl : CTL_NONE;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // halt goes high on the same edge that enters HALTED and stays there.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else begin
            halt <= (nextState == HALTED);
        end
    end

    // Counts edges where the PC is held outside HALTED; pins at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stallCount <= 16'd0;
        end else if ((state != HALTED) && !pcEN && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

endmodule
